// File: rtl/fma16_pkg.sv
// Shared types and constants for the fp16 FMA scheduler.
package fma16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int NREQ = 2;

    localparam int NV = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;

    localparam logic [1:0] RM_RZ  = 2'b00;
    localparam logic [1:0] RM_RNE = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

endpackage

// File: rtl/fma16_rr_arb.sv
// Two-way round-robin arbiter; the last pointer moves only on an accepted request.
module fma16_rr_arb
    import fma16_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    input  logic            accept,
    output logic            grant
);

    logic last_q;

    // A lone requester wins outright; a tie goes to whoever did not win last.
    always_comb begin
        grant = ~last_q;
        if (valid == 2'b01)
            grant = 1'b0;
        else if (valid == 2'b10)
            grant = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= 1'b1;
        else if (accept)
            last_q <= grant;
    end

endmodule

// File: rtl/fma16_sched.sv
// Shares one fp16 FMA datapath between two requesters: arbitrate, hold operands
// for CORE_LAT cycles, capture the result and return it on a tagged response.
module fma16_sched
    import fma16_pkg::*;
#(
    parameter int CORE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][15:0] req_x,
    input  logic [NREQ-1:0][15:0] req_y,
    input  logic [NREQ-1:0][15:0] req_z,
    input  logic [NREQ-1:0]       req_mul,
    input  logic [NREQ-1:0]       req_add,
    input  logic [NREQ-1:0]       req_negp,
    input  logic [NREQ-1:0]       req_negz,
    input  logic [NREQ-1:0][1:0]  req_roundmode,
    output logic [15:0]           core_x,
    output logic [15:0]           core_y,
    output logic [15:0]           core_z,
    output logic                  core_mul,
    output logic                  core_add,
    output logic                  core_negp,
    output logic                  core_negz,
    output logic [1:0]            core_roundmode,
    input  logic [15:0]           core_result,
    input  logic [3:0]            core_flags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [15:0]           rsp_result,
    output logic [3:0]            rsp_flags,
    output logic [NREQ-1:0][3:0]  fflags,
    input  logic [NREQ-1:0]       fflags_clr
);

    localparam logic [3:0] CNT_INIT = 4'(CORE_LAT - 1);

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  id_q;
    logic [15:0]           x_q, y_q, z_q;
    logic                  mul_q, add_q, negp_q, negz_q;
    logic [1:0]            rm_q;
    logic [15:0]           res_q;
    logic [3:0]            flg_q;
    logic [NREQ-1:0][3:0]  fflags_q, fflags_d;

    logic grant;
    logic accept;
    logic retire;

    fma16_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (reset_n),
        .valid  (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign req_ready = (state_q == IDLE) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign retire    = (state_q == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            id_q    <= 1'b0;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            z_q     <= 16'd0;
            mul_q   <= 1'b0;
            add_q   <= 1'b0;
            negp_q  <= 1'b0;
            negz_q  <= 1'b0;
            rm_q    <= 2'd0;
            res_q   <= 16'd0;
            flg_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q    <= grant;
                        x_q     <= req_x[grant];
                        y_q     <= req_y[grant];
                        z_q     <= req_z[grant];
                        mul_q   <= req_mul[grant];
                        add_q   <= req_add[grant];
                        negp_q  <= req_negp[grant];
                        negz_q  <= req_negz[grant];
                        rm_q    <= req_roundmode[grant];
                        cnt_q   <= CNT_INIT;
                        state_q <= EXEC;
                    end
                end
                // The datapath has had CORE_LAT cycles of stable inputs when the count reaches zero.
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        res_q   <= core_result;
                        flg_q   <= core_flags;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A clear and a retire in the same cycle keep only the retiring flags.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            fflags_d[i] = (fflags_clr[i] ? 4'd0 : fflags_q[i])
                        | ((retire && (id_q == 1'(i))) ? flg_q : 4'd0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fflags_q <= '0;
        else
            fflags_q <= fflags_d;
    end

    assign core_x         = x_q;
    assign core_y         = y_q;
    assign core_z         = z_q;
    assign core_mul       = mul_q;
    assign core_add       = add_q;
    assign core_negp      = negp_q;
    assign core_negz      = negz_q;
    assign core_roundmode = rm_q;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_id         = id_q;
    assign rsp_result     = res_q;
    assign rsp_flags      = flg_q;
    assign fflags         = fflags_q;

endmodule

// File: tb/tb_fma16_sched.sv
// Directed bench for fma16_sched with a stub datapath returning fixed results.
module tb_fma16_sched;
    localparam int LAT = 4;
    localparam int TMO = 50;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][15:0] req_x = '0, req_y = '0, req_z = '0;
    logic [1:0]       req_mul = '0, req_add = '0, req_negp = '0, req_negz = '0;
    logic [1:0][1:0]  req_roundmode = '0;
    logic [15:0]      core_x, core_y, core_z;
    logic             core_mul, core_add, core_negp, core_negz;
    logic [1:0]       core_roundmode;
    logic [15:0]      core_result;
    logic [3:0]       core_flags;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic             rsp_id;
    logic [15:0]      rsp_result;
    logic [3:0]       rsp_flags;
    logic [1:0][3:0]  fflags;
    logic [1:0]       fflags_clr = '0;

    int n_tests = 0;
    int n_fail  = 0;

    fma16_sched #(.CORE_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .req_mul(req_mul), .req_add(req_add), .req_negp(req_negp), .req_negz(req_negz),
        .req_roundmode(req_roundmode),
        .core_x(core_x), .core_y(core_y), .core_z(core_z),
        .core_mul(core_mul), .core_add(core_add), .core_negp(core_negp), .core_negz(core_negz),
        .core_roundmode(core_roundmode),
        .core_result(core_result), .core_flags(core_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .fflags(fflags), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    // Stub datapath: two known fp16 cases, otherwise result = x ^ y and flags = z[3:0].
    always_comb begin
        core_result = core_x ^ core_y;
        core_flags  = core_z[3:0];
        if (core_x == 16'h3C00 && core_y == 16'h4000) begin
            core_result = 16'h4200;
            core_flags  = 4'b0000;
        end else if (core_x == 16'h7BFF && core_y == 16'h4000) begin
            core_result = 16'h7C00;
            core_flags  = 4'b0101;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        req_x[r] = x;
        req_y[r] = y;
        req_z[r] = z;
        req_mul[r] = 1'b1;
        req_add[r] = 1'b1;
        req_roundmode[r] = 2'b01;
    endtask

    // Present one request, wait for its ready, and return just after the accepting edge.
    task automatic issue(input int r, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        int n;
        set_req(r, x, y, z);
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[r] && n < TMO) begin
            tick();
            n++;
        end
        if (n >= TMO) check_val("issue_timeout", 32'(n), 32'(0));
        tick();
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < TMO) begin
            tick();
            n++;
        end
        if (n >= TMO) check_val("rsp_timeout", 32'(n), 32'(0));
    endtask

    initial begin
        int n;
        logic [15:0] held;

        // Reset state
        #12;
        req_valid = 2'b01;
        #1;
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_core_x", 32'(core_x), 32'd0);
        check_val("rst_fflags", 32'(fflags), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        reset_n = 1'b1;
        tick();

        // Single request on requester 0
        issue(0, 16'h3C00, 16'h4000, 16'h3C00);
        check_val("single_core_x", 32'(core_x), 32'h3C00);
        check_val("single_core_rm", 32'(core_roundmode), 32'b01);
        check_val("single_ready_exec", 32'(req_ready), 32'b00);
        wait_rsp(n);
        check_val("single_latency", 32'(n), 32'(LAT));
        check_val("single_id", 32'(rsp_id), 32'd0);
        check_val("single_result", 32'(rsp_result), 32'h4200);
        tick();
        check_val("single_fflags0", 32'(fflags[0]), 32'd0);
        check_val("single_idle", 32'(rsp_valid), 32'd0);

        // Overflow on requester 1
        issue(1, 16'h7BFF, 16'h4000, 16'h0000);
        wait_rsp(n);
        check_val("ovf_id", 32'(rsp_id), 32'd1);
        check_val("ovf_result", 32'(rsp_result), 32'h7C00);
        check_val("ovf_flags", 32'(rsp_flags), 32'b0101);
        tick();
        check_val("ovf_fflags1", 32'(fflags[1]), 32'b0101);
        check_val("ovf_fflags0", 32'(fflags[0]), 32'b0000);

        // Both valid continuously: grants alternate 0,1,0,1
        set_req(0, 16'h1111, 16'h0000, 16'h0000);
        set_req(1, 16'h2222, 16'h0000, 16'h0008);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(n);
            check_val($sformatf("rr_id%0d", i), 32'(rsp_id), 32'(i % 2));
            check_val($sformatf("rr_res%0d", i), 32'(rsp_result), (i % 2) ? 32'h2222 : 32'h1111);
            tick();
        end
        req_valid = 2'b00;
        check_val("rr_fflags1", 32'(fflags[1]), 32'b1101);
        check_val("rr_fflags0", 32'(fflags[0]), 32'b0000);

        // Consumer stalls for 5 cycles with both requests pending
        rsp_ready = 1'b0;
        issue(0, 16'h1234, 16'h0000, 16'h0000);
        wait_rsp(n);
        req_valid = 2'b11;
        #1;
        held = rsp_result;
        check_val("stall_held", 32'(held), 32'h1234);
        for (int i = 0; i < 5; i++) begin
            check_val("stall_valid", 32'(rsp_valid), 32'd1);
            check_val("stall_result", 32'(rsp_result), 32'h1234);
            check_val("stall_id", 32'(rsp_id), 32'd0);
            check_val("stall_ready", 32'(req_ready), 32'b00);
            tick();
        end
        check_val("stall_core_x", 32'(core_x), 32'h1234);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        check_val("stall_release", 32'(rsp_valid), 32'd0);

        // Clear coinciding with a requester-1 retire
        fflags_clr = 2'b10;
        tick();
        fflags_clr = 2'b00;
        check_val("clr_only", 32'(fflags[1]), 32'd0);
        issue(1, 16'h0F0F, 16'h0000, 16'h0004);
        wait_rsp(n);
        tick();
        check_val("clr_pre", 32'(fflags[1]), 32'b0100);
        rsp_ready = 1'b0;
        issue(1, 16'h0F0F, 16'h0000, 16'h0001);
        wait_rsp(n);
        rsp_ready = 1'b1;
        fflags_clr = 2'b10;
        tick();
        fflags_clr = 2'b00;
        check_val("clr_and_retire", 32'(fflags[1]), 32'b0001);

        // Reset in the middle of EXEC
        issue(0, 16'h5555, 16'h0000, 16'h0002);
        tick();
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_core_x", 32'(core_x), 32'd0);
        check_val("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("mid_rst_fflags", 32'(fflags), 32'd0);
        check_val("mid_rst_rsp_result", 32'(rsp_result), 32'd0);
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) tick();
        check_val("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        issue(1, 16'h00FF, 16'h0F00, 16'h0000);
        wait_rsp(n);
        check_val("post_rst_latency", 32'(n), 32'(LAT));
        check_val("post_rst_id", 32'(rsp_id), 32'd1);
        check_val("post_rst_result", 32'(rsp_result), 32'h0FFF);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fma16_sched.md
# fma16_sched

Shares one half-precision FMA datapath (multiply, add, round) between two requesters. Accepts operations over per-requester valid/ready channels, picks one by round-robin, holds its operands and rounding mode steady on the datapath inputs for a fixed number of cycles, then captures the result and returns it on a single tagged response channel. Keeps a sticky exception-flag register per requester. Sits between the instruction-side issue logic and the datapath core (multiply, align/add, normalize, round).

## Interface
Parameters:
- `CORE_LAT`, default 1: cycles from datapath inputs stable to result valid. Legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  [1:0]  request valid, per requester.
- `req_ready`  out  [1:0]  request accepted, per requester.
- `req_x`, `req_y`, `req_z`  in  [1:0][15:0]  fp16 operands.
- `req_mul`, `req_add`, `req_negp`, `req_negz`  in  [1:0]  operation controls.
- `req_roundmode`  in  [1:0][1:0]  rounding mode: 00 RZ, 01 RNE, 10 RDN, 11 RUP.
- `core_x`, `core_y`, `core_z`  out  16  operands to the datapath.
- `core_mul`, `core_add`, `core_negp`, `core_negz`  out  1  controls to the datapath.
- `core_roundmode`  out  2  rounding mode to the datapath.
- `core_result`  in  16  datapath result.
- `core_flags`  in  4  datapath flags, ordered {nv, of, uf, nx}.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `rsp_id`  out  1  which requester the response belongs to.
- `rsp_result`  out  16  result.
- `rsp_flags`  out  4  flags for this operation.
- `fflags`  out  [1:0][3:0]  sticky accumulated flags, per requester.
- `fflags_clr`  in  [1:0]  synchronous clear of `fflags[i]`.

## Operation
- FSM states:
  - IDLE: the datapath is free.
  - EXEC: an operation is on the datapath inputs; a cycle counter runs.
  - RESP: the response is held until the consumer takes it.
- IDLE:
  - `req_ready[g]` is high, combinationally, only for the granted requester `g`; `req_ready` is 0 in EXEC and RESP.
  - On `req_valid[g]` with `req_ready[g]`: load the operand/control registers, `id`←g, counter←CORE_LAT-1, go to EXEC.
- Arbitration is round-robin:
  - With a single valid request, that requester is granted.
  - With both valid, grant the requester other than `last`.
  - `last` updates only on an accepted request. Reset value is `last`=1, so requester 0 wins the first tie.
- EXEC:
  - `core_*` outputs come straight from the registers and are stable for the whole state.
  - Counter at 0: capture `core_result` and `core_flags` into the response registers, go to RESP. Otherwise decrement the counter.
- RESP:
  - `rsp_valid`=1; `rsp_id`, `rsp_result` and `rsp_flags` are stable.
  - On `rsp_ready`: `fflags[id]` |= `rsp_flags`, go to IDLE.
- Sticky flags, per requester `i`, each cycle: `fflags[i]` ← (`fflags_clr[i]` ? 0 : `fflags[i]`) | (retire for `i` this cycle ? `rsp_flags` : 0). A clear and a retire in the same cycle therefore leave only the retiring flags.
- `rsp_valid` never drops without `rsp_ready`. Request inputs are sampled only at acceptance.
- `core_*` registers keep their last value in IDLE and RESP.

## Timing
- Reset, asynchronous, any state:
  - state←IDLE, `last`←1, counter←0.
  - All `core_*`, `rsp_*` and `fflags` ← 0; `rsp_valid`=0; `req_ready` is recomputed in IDLE.
  - Any in-flight operation is discarded with no response.
- Latency:
  - Request accepted at edge k.
  - `core_*` valid from k.
  - Result captured at edge k+CORE_LAT.
  - `rsp_valid` high from k+CORE_LAT.
- Throughput with `rsp_ready` held high: one operation per CORE_LAT+2 cycles.
- The datapath must settle its result within CORE_LAT cycles of stable inputs. The scheduler inserts no extra margin.

## Structure
- `fma16_pkg`:
  - state enum {IDLE, EXEC, RESP};
  - flag index constants NV=3, OF=2, UF=1, NX=0;
  - rounding-mode constants;
  - NREQ=2.
- Sub-module `fma16_rr_arb`: 2-way round-robin grant plus the `last` pointer (inputs `valid[1:0]` and `accept`; output `grant`).
- The datapath core is instantiated outside this block.

## Test plan
- Single request on requester 0: x=0x3C00, y=0x4000, z=0x3C00, mul=add=1, rm=01, bench core returns 0x4200 / flags 0 → `rsp_valid` at k+CORE_LAT, `rsp_id`=0, `rsp_result`=0x4200, `fflags[0]`=0.
- Both requesters valid continuously for 4 operations → grants 0,1,0,1; each response carries the matching id.
- Overflow on requester 1: x=0x7BFF, y=0x4000, z=0, core returns 0x7C00 / 4'b0101 → `fflags[1]`=0101, `fflags[0]` unchanged.
- `rsp_ready` held low 5 cycles → `rsp_valid` and the response data stay stable, `req_ready`=00, and no new accept occurs.
- `fflags_clr[1]` in the same cycle as a requester-1 retire with flags 0001, old `fflags[1]`=0100 → `fflags[1]`=0001.
- `reset_n` low during EXEC with CORE_LAT=4 → immediate IDLE, all outputs 0, no response; the next request is accepted normally.
